uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter on the CPU data bus, downstream of the multicycle RV32I core. Decodes the core's `mem_addr` / `mem_wr_data` / `mem_wr_ena` for its address window and queues written bytes in a FIFO. Serialises bytes as 8N1 frames on `tx`. Returns a read word that the system memory mux selects when `sel` is high.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_1000: window base; must be 16-byte aligned.
- `CLKS_PER_BIT`, 104: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 8: byte FIFO depth; power of two, 2..16.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset. One clock; reset is asynchronous and active-low.
- `mem_addr` in 32: core memory address.
- `mem_wr_data` in 32: core write data.
- `mem_wr_ena` in 1: core write strobe.
- `rd_data` out 32: combinational read data for the addressed register; 0 outside the window.
- `sel` out 1: combinational; high when `mem_addr[31:4] == BASE_ADDR[31:4]`.
- `tx` out 1: serial output, registered, idle high.

## Operation
Register map (offset = `mem_addr[3:0]`; any other offset reads 0 and ignores writes):
- 0x0 TXDATA: a write pushes `mem_wr_data[7:0]`. Reads return 0.
- 0x4 STATUS: read-only except bit 3.
  - bit0 = full; bit1 = empty; bit2 = busy (FSM not IDLE).
  - bit3 = overflow, sticky. Writing 1 to bit 3 clears it.
  - bits[8:4] = FIFO count. All other bits 0.
- 0x8 CTRL: bit0 = enable, read/write. All other bits 0.

FIFO:
- Circular buffer with read/write pointers and a count. Pointers wrap modulo `FIFO_DEPTH`.
- A push is accepted when count < `FIFO_DEPTH`, or when a pop occurs on the same edge.
- On a simultaneous push and pop, count is unchanged.
- A rejected push leaves FIFO contents unchanged and sets overflow.
- If an overflow-clear write and a new overflow coincide, overflow ends set.

Transmit FSM, states IDLE, START, DATA, STOP:
- A baud counter counts 0..`CLKS_PER_BIT`-1 and a bit index counts 0..7.
- IDLE, with count > 0 and enable = 1: pop the head byte into the shift register, `tx` <= 0, go to START, clear the baud counter.
- START: at baud terminal count, `tx` <= shift[0], go to DATA with bit index = 0.
- DATA: at each terminal count, shift right.
  - If bit index < 7: increment the index and drive the next bit.
  - If bit index = 7: `tx` <= 1 and go to STOP.
- STOP, at terminal count:
  - If count > 0 and enable = 1: pop, `tx` <= 0, go to START (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- Clearing enable mid-frame does not abort: the current frame completes, then the FSM idles. Bytes already queued stay queued.

Reset (asserted, asynchronously):
- `tx` = 1, state = IDLE, FIFO empty (pointers and count 0), overflow = 0, enable = 1.
- STATUS reads 0x0000_0002.
- Reset mid-frame truncates the frame immediately; `tx` goes high.

## Timing
- Register writes occur on the rising edge where `mem_wr_ena` = 1 and the address matches.
- Reads are combinational from `mem_addr`, valid in the same cycle. They reflect state after the most recent edge.
- Latency from a write to the start bit: write at edge k gives count = 1 after edge k. The pop happens at edge k+1, and `tx` falls after edge k+1.
- Each bit lasts exactly `CLKS_PER_BIT` cycles. A frame is 10 × `CLKS_PER_BIT` cycles.
- Back-to-back frames are contiguous.
- busy rises with the pop edge. It falls on the STOP terminal edge when no further pop occurs.

## Test plan
- Reset, `CLKS_PER_BIT`=4: `tx`=1; STATUS=0x2; CTRL=0x1; no window → `rd_data`=0, `sel`=0.
- Write 0xA5 to TXDATA → `tx` low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. Total 40 cycles; busy=1 throughout, then STATUS=0x2.
- Write 0x55 then 0x0F on consecutive writes → two frames with no gap (80 cycles). The stop bit is followed directly by the second start bit.
- Clear enable, write 9 bytes (depth 8) → STATUS = full=1, count=8, overflow=1, `tx` stays 1. Write 0x8 to STATUS → overflow=0. Set enable → eight frames in write order.
- FIFO full while STOP ends with a pop, plus a simultaneous TXDATA write → push accepted, count stays 8, overflow stays 0.
- Assert `rst` mid-DATA on bit 3 → `tx`=1 immediately; after release STATUS=0x2 and no further frames.

Source files
------------

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: core data-bus signals shared by the CPU and the memory-mapped UART transmitter
// mem_addr/mem_wr_data/mem_wr_ena: driven by the core (master)
// rd_data/sel: driven by the peripheral (slave) back to the system read mux
interface uart_tx_mmio_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic mem_wr_ena;
  logic [31:0] rd_data;
  logic sel;
  modport master(output mem_addr, mem_wr_data, mem_wr_ena, input rd_data, sel);
  modport slave(input mem_addr, mem_wr_data, mem_wr_ena, output rd_data, sel);
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a byte FIFO
// clk: system clock; rst: asynchronous active-low reset
// bus: core address/write strobe in, combinational rd_data/sel out
// tx: registered serial output, idle high
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  uart_tx_mmio_if.slave bus,
  output logic tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic [3:0] off;
  logic ovf, en, pop, push, wr_tx, wr_st, wr_ct, full, empty, tc, tx_n, can_pop;
  assign off = bus.mem_addr[3:0];
  assign bus.sel = bus.mem_addr[31:4] == BASE_ADDR[31:4];
  assign wr_tx = bus.mem_wr_ena && bus.sel && off == 4'h0;
  assign wr_st = bus.mem_wr_ena && bus.sel && off == 4'h4;
  assign wr_ct = bus.mem_wr_ena && bus.sel && off == 4'h8;
  assign full = cnt == CW'(FIFO_DEPTH);
  assign empty = cnt == '0;
  // a full FIFO still takes a byte when the transmitter pops on the same edge
  assign push = wr_tx && (!full || pop);
  assign tc = baud == BW'(CLKS_PER_BIT - 1);
  assign can_pop = en && !empty;
  assign bus.rd_data = !bus.sel ? '0
                     : off == 4'h4 ? {23'd0, 5'(cnt), ovf, state != IDLE, empty, full}
                     : off == 4'h8 ? {31'd0, en} : '0;
  always_comb begin
    state_n = state;
    baud_n = tc ? '0 : baud + 1'b1;
    idx_n = idx;
    shift_n = shift;
    tx_n = tx;
    pop = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (can_pop) begin
          pop = 1'b1;
          shift_n = fifo[rptr];
          tx_n = 1'b0;
          state_n = START;
        end
      end
      START: if (tc) begin
        tx_n = shift[0];
        idx_n = '0;
        state_n = DATA;
      end
      DATA: if (tc) begin
        shift_n = {1'b0, shift[7:1]};
        tx_n = idx == 3'd7 ? 1'b1 : shift[1];
        idx_n = idx + 3'd1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (tc) begin
        // chain straight into the next start bit so frames stay contiguous
        pop = can_pop;
        shift_n = can_pop ? fifo[rptr] : shift;
        tx_n = !can_pop;
        state_n = can_pop ? START : IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      baud <= '0;
      idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      en <= 1'b1;
    end else begin
      state <= state_n;
      baud <= baud_n;
      idx <= idx_n;
      shift <= shift_n;
      tx <= tx_n;
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      cnt <= cnt + CW'(push) - CW'(pop);
      // a fresh overflow wins over a coincident clear
      ovf <= (wr_tx && !push) || (ovf && !(wr_st && bus.mem_wr_data[3]));
      en <= wr_ct ? bus.mem_wr_data[0] : en;
    end
  end
  always_ff @(posedge clk) if (push) fifo[wptr] <= bus.mem_wr_data[7:0];
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: randomized scoreboard bench for uart_tx_mmio against a byte-level reference model
module tb_uart_tx_mmio;
  localparam int CPB = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'd4;
  localparam logic [31:0] A_CT = BASE + 32'd8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;
  uart_tx_mmio_if bus();
  uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx)
  );
  always #5 clk = ~clk;
  typedef struct {logic [7:0] b; int edge_n;} frame_t;
  frame_t exp_q[$];
  logic [7:0] mq[$];
  logic m_ovf, m_en;
  int free_at, cyc, n_vec, n_err;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic void model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_en = 1'b1;
    free_at = 0;
  endfunction
  // one clock edge of the reference: the line becomes free FRAME edges after a byte starts
  function automatic void model_edge(logic we, logic [31:0] a, logic [31:0] d);
    frame_t f;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_en && mq.size() > 0 && cyc >= free_at) begin
      f.b = mq.pop_front();
      f.edge_n = cyc;
      exp_q.push_back(f);
      free_at = cyc + FRAME;
    end
    if (we && (a >> 4) == (BASE >> 4)) begin
      if (a[3:0] == 4'h0) begin
        if (mq.size() < DEPTH) mq.push_back(d[7:0]);
        else m_ovf = 1'b1;
      end else if (a[3:0] == 4'h4) begin
        if (d[3]) m_ovf = 1'b0;
      end else if (a[3:0] == 4'h8) m_en = d[0];
    end
  endfunction
  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int c;
    c = mq.size();
    s = '0;
    s[8:4] = 5'(c);
    s[3] = m_ovf;
    s[2] = cyc < free_at;
    s[1] = c == 0;
    s[0] = c == DEPTH;
    return s;
  endfunction
  task automatic cyc_op(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.mem_addr = a;
    bus.mem_wr_data = d;
    bus.mem_wr_ena = we;
    @(posedge clk);
    cyc++;
    model_edge(we, a, d);
    #1 bus.mem_wr_ena = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.mem_addr = a;
    bus.mem_wr_ena = 1'b0;
    #1 v = bus.rd_data;
  endtask
  task automatic chk_status(input string name);
    logic [31:0] v;
    rd(A_ST, v);
    chk(name, v, exp_status());
  endtask
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((mq.size() > 0 || cyc < free_at || exp_q.size() > 0) && n < 3000) begin
      cyc_op(1'b0, A_ST, 32'd0);
      n++;
    end
    cyc_op(1'b0, A_ST, 32'd0);
    chk(name, 64'(n < 3000), 64'd1);
  endtask
  initial begin
    logic [63:0] wave, ew;
    frame_t e;
    bit have, aborted;
    int k0;
    forever begin
      @(negedge clk);
      if (rst && tx === 1'b0) begin
        k0 = cyc;
        have = exp_q.size() > 0;
        if (have) e = exp_q.pop_front();
        else begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_frame: start bit after edge %0d, expected line idle", k0);
        end
        wave = '0;
        aborted = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst) begin
            aborted = 1'b1;
            break;
          end
          wave[i] = tx;
        end
        if (have && !aborted) begin
          ew = '0;
          for (int i = 0; i < FRAME; i++)
            ew[i] = i < CPB ? 1'b0 : i < 9 * CPB ? e.b[(i - CPB) / CPB] : 1'b1;
          chk("frame_wave", wave, ew);
          chk("frame_start_edge", 64'(k0), 64'(e.edge_n));
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    logic [31:0] v;
    int r;
    bus.mem_addr = '0;
    bus.mem_wr_data = '0;
    bus.mem_wr_ena = 1'b0;
    cyc = 0;
    n_vec = 0;
    n_err = 0;
    model_reset();
    repeat (3) cyc_op(1'b0, 32'd0, 32'd0);
    chk("tx_in_reset", 64'(tx), 64'd1);
    rst = 1'b1;
    #1 chk("tx_after_reset", 64'(tx), 64'd1);
    rd(A_ST, v);
    chk("status_reset", 64'(v), 64'h2);
    rd(A_CT, v);
    chk("ctrl_reset", 64'(v), 64'h1);
    chk("sel_in_window", 64'(bus.sel), 64'd1);
    rd(32'h0000_2004, v);
    chk("rd_outside", 64'(v), 64'd0);
    chk("sel_outside", 64'(bus.sel), 64'd0);
    rd(BASE + 32'd12, v);
    chk("rd_unmapped", 64'(v), 64'd0);
    cyc_op(1'b1, A_TX, 32'hA5);
    repeat (45) begin
      cyc_op(1'b0, A_ST, 32'd0);
      chk_status("status_a5");
    end
    rd(A_ST, v);
    chk("status_after_a5", 64'(v), 64'h2);
    cyc_op(1'b1, A_TX, 32'h55);
    cyc_op(1'b1, A_TX, 32'h0F);
    repeat (85) begin
      cyc_op(1'b0, A_ST, 32'd0);
      chk_status("status_b2b");
    end
    cyc_op(1'b1, A_CT, 32'd0);
    repeat (9) cyc_op(1'b1, A_TX, 32'($urandom_range(0, 255)));
    rd(A_ST, v);
    chk("status_overflow", 64'(v), 64'h89);
    chk("tx_disabled", 64'(tx), 64'd1);
    cyc_op(1'b1, A_ST, 32'h8);
    rd(A_ST, v);
    chk("status_ovf_clear", 64'(v), 64'h81);
    cyc_op(1'b1, A_CT, 32'd1);
    drain("drain_overflow");
    cyc_op(1'b1, A_CT, 32'd0);
    repeat (8) cyc_op(1'b1, A_TX, 32'($urandom_range(0, 255)));
    cyc_op(1'b1, A_CT, 32'd1);
    cyc_op(1'b1, A_TX, 32'($urandom_range(0, 255)));
    repeat (39) cyc_op(1'b0, A_ST, 32'd0);
    cyc_op(1'b1, A_TX, 32'($urandom_range(0, 255)));
    rd(A_ST, v);
    chk("status_full_pop_push", 64'(v & 32'h1F9), 64'h81);
    chk_status("status_full_pop_model");
    drain("drain_full_pop");
    repeat (600) begin
      r = $urandom_range(0, 99);
      if (r < 45) cyc_op(1'b1, A_TX, $urandom);
      else if (r < 52) cyc_op(1'b1, A_ST, $urandom);
      else if (r < 58) cyc_op(1'b1, A_CT, 32'($urandom_range(0, 3) != 0));
      else if (r < 61) cyc_op(1'b1, r[0] ? BASE + 32'd12 : 32'h0000_2000, $urandom);
      else cyc_op(1'b0, A_ST, 32'd0);
      chk_status("status_rand");
    end
    cyc_op(1'b1, A_CT, 32'd1);
    drain("drain_rand");
    cyc_op(1'b1, A_TX, 32'h3C);
    cyc_op(1'b1, A_TX, 32'h99);
    repeat (16) cyc_op(1'b0, A_ST, 32'd0);
    #1 rst = 1'b0;
    model_reset();
    #1 chk("tx_reset_midframe", 64'(tx), 64'd1);
    rd(A_ST, v);
    chk("status_in_reset", 64'(v), 64'h2);
    repeat (2) cyc_op(1'b0, A_ST, 32'd0);
    rst = 1'b1;
    rd(A_ST, v);
    chk("status_post_reset", 64'(v), 64'h2);
    repeat (60) cyc_op(1'b0, A_ST, 32'd0);
    chk_status("status_quiet");
    chk("pending_frames", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
